// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision definitions for the calculator datapath
// (divider now, multiplier when it is refactored).
package fp32_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int BIAS      = 127;
  localparam int EXP_MAX   = 255;
  localparam int DIV_STEPS = 25;
  localparam int CNT_W     = 5;

  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_PACK = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  // Apply a sign to an unsigned magnitude encoding (zero or infinity).
  function automatic logic [31:0] fp_signed(input logic s, input logic [31:0] mag);
    return {s, mag[30:0]};
  endfunction

endpackage

// File: rtl/mant_div_step.sv
// One restoring-division step: subtract the divisor if it fits, then shift.
module mant_div_step (
  input  logic [25:0] r_i,
  input  logic [24:0] d_i,
  output logic [25:0] r_next_o,
  output logic        q_bit_o
);

  logic [25:0] diff;

  // Trial subtraction; the remainder always stays below 2*D so 26 bits suffice.
  always_comb begin
    diff     = r_i - {1'b0, d_i};
    q_bit_o  = (r_i >= {1'b0, d_i});
    r_next_o = q_bit_o ? {diff[24:0], 1'b0} : {r_i[24:0], 1'b0};
  end

endmodule

// File: rtl/div32.sv
// Sequential IEEE-754 single divider: 25 restoring steps, one pack cycle.
module div32
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  div_state_t         state_q;
  logic               sign_q;
  logic [EXP_W-1:0]   ea_q, eb_q;
  logic [25:0]        r_q;
  logic [24:0]        d_q;
  logic [24:0]        q_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               za_q, zb_q;
  logic [31:0]        result_q;
  logic               busy_q, done_q;

  logic [25:0]        r_nxt;
  logic               q_bit;
  logic signed [9:0]  etmp;
  logic [MAN_W-1:0]   mant;
  logic [31:0]        result_d;

  mant_div_step u_step (
    .r_i      (r_q),
    .d_i      (d_q),
    .r_next_o (r_nxt),
    .q_bit_o  (q_bit)
  );

  // Normalize the quotient and resolve special cases in priority order.
  always_comb begin
    etmp = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
         + (q_q[24] ? 10'sd127 : 10'sd126);
    mant = q_q[24] ? q_q[23:1] : q_q[22:0];
    if (za_q)
      result_d = fp_signed(sign_q, FP_ZERO);
    else if (zb_q)
      result_d = fp_signed(sign_q, FP_POS_INF);
    else if (etmp >= 10'sd255)
      result_d = fp_signed(sign_q, FP_POS_INF);
    else if (etmp <= 10'sd0)
      result_d = fp_signed(sign_q, FP_ZERO);
    else
      result_d = {sign_q, etmp[7:0], mant};
  end

  // Control FSM and datapath registers; en freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      r_q      <= '0;
      d_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      za_q     <= 1'b0;
      zb_q     <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (en) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (load) begin
            sign_q  <= A[31] ^ B[31];
            ea_q    <= A[30:23];
            eb_q    <= B[30:23];
            r_q     <= {3'b001, A[22:0]};
            d_q     <= {2'b01, B[22:0]};
            q_q     <= '0;
            cnt_q   <= '0;
            za_q    <= (A[30:23] == '0);
            zb_q    <= (B[30:23] == '0);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= ST_DIV;
          end
        end
        ST_DIV: begin
          r_q   <= r_nxt;
          q_q   <= {q_q[23:0], q_bit};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_STEPS - 1))
            state_q <= ST_PACK;
        end
        ST_PACK: begin
          result_q <= result_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_div32.sv
// Self-checking bench for div32: directed cases plus random operands
// against an integer-arithmetic reference of IEEE single division.
module tb_div32;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        busy, done;

  int n_checks = 0;
  int n_fails  = 0;

  div32 dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .load   (load),
    .A      (A),
    .B      (B),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Reference: quotient of the 1.m significands as a 25-bit fixed-point
  // integer floor(ma * 2^24 / mb), then normalize and range-check.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic   s;
    int     ea, eb, e;
    longint ma, mb, q, mant;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0) return {s, 31'h0};
    if (eb == 0) return {s, 8'hFF, 23'h0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    q  = (ma * 64'd16777216) / mb;
    if (q >= 64'd16777216) begin
      e    = ea - eb + 127;
      mant = (q / 2) % 64'd8388608;
    end else begin
      e    = ea - eb + 126;
      mant = q % 64'd8388608;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one division, optionally with an en gap and a stray load while busy,
  // then check latency (in edges after the load edge) and the packed result.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input int gap_start, input int gap_len, input bit poke,
                     input string tag);
    logic [31:0] exp_res;
    int          edges;
    exp_res = model(a, b);
    A = a; B = b; en = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    chk1({tag, "_busy_on_load"}, busy, 1'b1);
    chk1({tag, "_done_low_on_load"}, done, 1'b0);
    edges = 0;
    while (done !== 1'b1 && edges < 300) begin
      en = !(edges >= gap_start && edges < gap_start + gap_len);
      if (poke && edges == 5) begin
        load = 1'b1;
        A = $urandom;
        B = $urandom;
      end else begin
        load = 1'b0;
      end
      tick();
      edges++;
    end
    en = 1'b1; load = 1'b0;
    chkn({tag, "_latency"}, edges, 26 + gap_len);
    chk1({tag, "_busy_end"}, busy, 1'b0);
    chk32({tag, "_result"}, result, exp_res);
  endtask

  logic [31:0] ra, rb, held;

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; A = '0; B = '0;
    tick(); tick();
    chk32("reset_result", result, 32'h0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_done", done, 1'b0);

    // rst wins over a simultaneous load
    en = 1'b1; load = 1'b1; A = 32'h40C00000; B = 32'h40000000;
    tick();
    chk1("rst_load_busy", busy, 1'b0);
    rst = 1'b0; load = 1'b0;
    tick();

    run(32'h40C00000, 32'h40000000, 1000, 0, 1'b0, "six_by_two");
    chk32("six_by_two_const", result, 32'h40400000);

    // done and result hold while idle
    held = result;
    repeat (3) tick();
    chk1("done_holds", done, 1'b1);
    chk32("result_holds", result, held);

    run(32'h3F800000, 32'h40400000, 1000, 0, 1'b0, "one_third");
    chk32("one_third_const", result, 32'h3EAAAAAA);
    run(32'hC0F00000, 32'h40200000, 1000, 0, 1'b0, "neg_div");
    chk32("neg_div_const", result, 32'hC0400000);
    run(32'h3F800000, 32'h00000000, 1000, 0, 1'b0, "div_zero");
    chk32("div_zero_const", result, 32'h7F800000);
    run(32'h80000000, 32'h40A00000, 1000, 0, 1'b0, "zero_num");
    chk32("zero_num_const", result, 32'h80000000);
    run(32'h00000000, 32'h00000000, 1000, 0, 1'b0, "zero_zero");
    chk32("zero_zero_const", result, 32'h00000000);
    run(32'h7F000000, 32'h00800000, 1000, 0, 1'b0, "overflow");
    chk32("overflow_const", result, 32'h7F800000);
    run(32'h00800000, 32'h7F000000, 1000, 0, 1'b0, "underflow");
    chk32("underflow_const", result, 32'h00000000);

    // en gap of 5 cycles mid-DIV plus a stray load while busy
    run(32'h40C00000, 32'h40000000, 10, 5, 1'b1, "en_gap_poke");
    chk32("en_gap_poke_const", result, 32'h40400000);

    // reset at DIV step 10 aborts
    A = 32'h3F800000; B = 32'h40400000; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (10) tick();
    chk1("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk32("abort_result", result, 32'h0);
    run(32'h40C00000, 32'h40000000, 1000, 0, 1'b0, "after_abort");

    // random operands, mostly in a non-saturating exponent band
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 != 0) begin
        ra[30:23] = 8'($urandom_range(100, 154));
        rb[30:23] = 8'($urandom_range(100, 154));
      end
      run(ra, rb, (i % 5 == 0) ? int'($urandom_range(0, 20)) : 1000,
          (i % 5 == 0) ? 3 : 0, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
